// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and its memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch sequencer: fetches one word, holds it for
// execution, then advances pc by +4, a relative branch or an indirect jump.
//
// state | meaning
// IDLE  | one-cycle gap after reset before the first request
// FETCH | imem_req high at pc, waiting for ack or timeout
// EXEC  | instr/pc held valid until exec_done
// HALT  | sticky fault, left only by reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       mem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic               indirect_branch,
  input  logic [31:0]        imm32,
  input  logic [31:0]        alu_result,
  output logic               fault,
  output logic [1:0]         fault_cause,
  output logic [31:0]        retired
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] TIMEOUT_LM = 32'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        req_q;
  logic        fault_q;
  logic [1:0]  cause_q;
  logic [31:0] retired_q;
  logic [31:0] tmo_cnt_q;
  logic [31:0] next_pc_d;

  // Branch target selection; indirect targets have bit 0 cleared, bit 1 may still misalign.
  always_comb begin
    next_pc_d = pc_q + 32'd4;
    if (branch_taken && indirect_branch) begin
      next_pc_d = alu_result & 32'hFFFF_FFFE;
    end else if (branch_taken) begin
      next_pc_d = pc_q + imm32;
    end
  end

  // Sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      req_q         <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= 2'b00;
      retired_q     <= 32'd0;
      tmo_cnt_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= FETCH;
          req_q     <= 1'b1;
          tmo_cnt_q <= 32'd0;
        end
        FETCH: begin
          if (mem.imem_ack) begin
            state_q       <= EXEC;
            instr_q       <= mem.imem_data;
            instr_valid_q <= 1'b1;
            req_q         <= 1'b0;
          end else if (tmo_cnt_q + 32'd1 >= TIMEOUT_LM) begin
            state_q <= HALT;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            cause_q <= 2'b10;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
          end
        end
        EXEC: begin
          if (exec_done) begin
            retired_q     <= retired_q + 32'd1;
            instr_valid_q <= 1'b0;
            if (next_pc_d[1:0] != 2'b00) begin
              state_q <= HALT;
              fault_q <= 1'b1;
              cause_q <= 2'b01;
            end else begin
              state_q   <= FETCH;
              pc_q      <= next_pc_d;
              req_q     <= 1'b1;
              tmo_cnt_q <= 32'd0;
            end
          end
        end
        default: begin
          req_q         <= 1'b0;
          instr_valid_q <= 1'b0;
          fault_q       <= 1'b1;
        end
      endcase
    end
  end

  assign mem.imem_req  = req_q;
  assign mem.imem_addr = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = instr_valid_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;
  assign retired       = retired_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum FETCH cycles without imem_ack before a fault.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  out  1  meaning the instruction memory read request.
REQ-006 SHALL have port imem_addr  out  32  meaning the byte address of the request, equal to pc.
REQ-007 SHALL have port imem_ack  in  1  meaning imem_data is valid this cycle.
REQ-008 SHALL have port imem_data  in  32  meaning the fetched instruction word.
REQ-009 SHALL have port instr  out  32  meaning the held instruction presented to the decoder.
REQ-010 SHALL have port instr_valid  out  1  meaning instr and pc are valid for execution.
REQ-011 SHALL have port pc  out  32  meaning the address of instr.
REQ-012 SHALL have port pc_plus4  out  32  meaning pc+4, the link value for JAL/JALR.
REQ-013 SHALL have port exec_done  in  1  meaning downstream has finished instr and the branch inputs are valid.
REQ-014 SHALL have port branch_taken  in  1  meaning take the branch/jump.
REQ-015 SHALL have port indirect_branch  in  1  meaning the target is taken from alu_result (JALR).
REQ-016 SHALL have port imm32  in  32  meaning the sign-extended branch/jump offset.
REQ-017 SHALL have port alu_result  in  32  meaning the ALU output, used as the JALR target.
REQ-018 SHALL have port fault  out  1  meaning sticky: the unit is halted.
REQ-019 SHALL have port fault_cause  out  2  meaning 00 none, 01 misaligned target, 10 fetch timeout.
REQ-020 SHALL have port retired  out  32  meaning the count of exec_done handshakes accepted.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, EXEC and HALT; IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-022 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_req SHALL be 0 in all other states.
REQ-023 In FETCH with imem_ack=1, the unit SHALL latch imem_data into instr and go to EXEC, so instr_valid=1 the cycle after ack.
REQ-024 In FETCH, the timeout counter SHALL increment on each cycle without ack.
REQ-025 When the timeout counter reaches TIMEOUT, the unit SHALL go to HALT with fault_cause=10.
REQ-026 If ack and timeout occur in the same cycle, ack SHALL win.
REQ-027 The timeout counter SHALL clear on entry to FETCH.
REQ-028 In EXEC, instr_valid SHALL be 1 and instr and pc SHALL be held stable until exec_done=1.
REQ-029 On exec_done in EXEC, next_pc SHALL be selected by priority, evaluated that same cycle:
- indirect_branch&branch_taken: {alu_result[31:1],1'b0}
- branch_taken: pc+imm32, mod 2^32
- otherwise: pc+4, mod 2^32
REQ-030 On exec_done in EXEC, if next_pc[1:0]!=00 the unit SHALL go to HALT with fault_cause=01 and pc unchanged.
REQ-031 On exec_done in EXEC with an aligned next_pc, pc SHALL take next_pc and the unit SHALL go to FETCH, so imem_req=1 with the new address the next cycle.
REQ-032 retired SHALL increment by 1 on every exec_done accepted in EXEC, including a faulting one, wrapping 32'hFFFF_FFFF->0.
REQ-033 imem_ack outside FETCH and exec_done outside EXEC SHALL be ignored.
REQ-034 HALT SHALL be exited only by reset; in HALT, fault=1, imem_req=0 and instr_valid=0.
REQ-035 pc_plus4 SHALL be combinational pc+4.
REQ-036 All other outputs SHALL be driven from registers.

Reset
REQ-037 While rst=1, the unit SHALL force state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fault=0, fault_cause=00, retired=0 and timeout counter=0.
REQ-038 Reset asserted mid-FETCH or mid-EXEC SHALL abort the operation immediately; a late imem_ack SHALL be ignored.
REQ-039 After rst falls, the first imem_req SHALL be asserted on the second rising edge (IDLE, then FETCH).

Verification
REQ-040 Sequential fetch: ack after 0 and 3 wait cycles, exec_done with branch_taken=0 -> imem_addr 0x0, 0x4, 0x8; retired=2.
REQ-041 BEQ taken: pc=0x10, branch_taken=1, imm32=0xFFFF_FFF8 -> next imem_addr=0x08.
REQ-042 JALR: pc=0x20, indirect=1, taken=1, alu_result=0x0000_0101 -> imem_addr=0x100; pc_plus4=0x24 in EXEC.
REQ-043 Misaligned: branch_taken=1, imm32=0x6, pc=0x0 -> HALT, fault=1, fault_cause=01, pc=0x0, imem_req stays 0.
REQ-044 Timeout: TIMEOUT=4, no ack -> fault_cause=10 after 4 FETCH cycles; ack arriving exactly on the 4th cycle -> EXEC, no fault.
REQ-045 Reset mid-EXEC with exec_done=1 the same cycle -> pc=RESET_PC, retired=0, instr_valid=0; a later ack is ignored.
